// File: rtl/mult_result_accumulator.sv
`timescale 1ns/1ps
// mult_result_accumulator
//   Accumulates a block of multiplier products (the sum of two 45-bit
//   partial-sum words) into a 48-bit accumulator. The accumulator is split
//   into 1, 2 or 4 independent lanes depending on the mode latched at the
//   first product of the block. Each lane wraps on overflow and records a
//   sticky overflow flag. After acc_len products the result is held for
//   the consumer.
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   in_valid      product words valid
//   in_ready      block accepts a product this cycle (low while holding a result)
//   in_result_0   first partial-sum word (45 bits)
//   in_result_1   second partial-sum word (45 bits)
//   in_simd_carry multiplier SIMD carry bits, OR-ed over the block
//   in_sign       operands are signed
//   mode          00 full, 01 sum_9x9 (2 lanes), 10/11 sum_4x4/2x2 (4 lanes)
//   acc_len       products per block, 0 means 1
//   out_valid     accumulated result valid (one block at a time)
//   out_ready     consumer accepts the result
//   out_acc       accumulated result
//   out_ovf       sticky per-lane overflow flags, bit k = lane k
//   out_carry_or  OR of in_simd_carry over the block
module mult_result_accumulator #(
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [44:0]      in_result_0,
  input  logic [44:0]      in_result_1,
  input  logic [15:0]      in_simd_carry,
  input  logic             in_sign,
  input  logic [1:0]       mode,
  input  logic [7:0]       acc_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [3:0]       out_ovf,
  output logic [15:0]      out_carry_or
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ACC_W-1:0] acc_reg;
  logic [3:0]       ovf_reg;
  logic [15:0]      carry_or_reg;
  logic [7:0]       cnt_reg;
  logic [7:0]       len_reg;
  logic [1:0]       mode_reg;
  logic             sign_reg;

  logic             accept;
  logic [7:0]       len_eff;
  logic [7:0]       cnt_inc;

  // Block configuration in effect for the current add: taken straight from
  // the ports on the first product, from the latched copy afterwards.
  logic             first_beat;
  logic [1:0]       mode_eff;
  logic             sign_eff;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] word_0;
  logic [ACC_W-1:0] word_1;
  logic [ACC_W-1:0] sum_word;
  logic [3:0]       seg_ovf;
  logic [3:0]       ovf_add;
  // seg_link[k] = 1 when carries from segment k-1 flow into segment k,
  // i.e. both 12-bit segments belong to the same lane.
  logic [3:1]       seg_link;

  // in_ready depends on state only, so accept has no combinational path
  // from out_ready or in_valid back into in_ready.
  assign accept     = in_valid && (state_reg != ST_HOLD);
  assign len_eff    = (acc_len == 8'd0) ? 8'd1 : acc_len;
  assign cnt_inc    = cnt_reg + 8'd1;
  assign first_beat = (state_reg == ST_IDLE);
  assign mode_eff   = first_beat ? mode    : mode_reg;
  assign sign_eff   = first_beat ? in_sign : sign_reg;
  assign acc_base   = first_beat ? '0      : acc_reg;

  // Only a single full-width signed lane sign-extends the 45-bit words;
  // narrower lanes always see the raw (zero-extended) bit fields.
  assign word_0 = (mode_eff == 2'b00 && sign_eff) ? {{3{in_result_0[44]}}, in_result_0}
                                                 : {3'b000, in_result_0};
  assign word_1 = (mode_eff == 2'b00 && sign_eff) ? {{3{in_result_1[44]}}, in_result_1}
                                                 : {3'b000, in_result_1};

  always_comb begin
    seg_link = 3'b000;
    case (mode_eff)
      2'b00:   seg_link = 3'b111;  // one 48-bit lane
      2'b01:   seg_link = 3'b101;  // lanes 23:0 and 47:24
      default: seg_link = 3'b000;  // four 12-bit lanes
    endcase
  end

  // Four 12-bit segments. A three-operand add carries out at most 2, so the
  // inter-segment carry is 2 bits wide. Signed overflow is judged on the
  // segment that tops a lane, using sign-extended segment operands plus the
  // (unsigned) carry from the lower segments of the same lane, which gives
  // the exact signed lane sum's upper part.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_seg
    logic [11:0]        a_seg;
    logic [11:0]        b_seg;
    logic [11:0]        c_seg;
    logic [1:0]         cin;
    logic [13:0]        usum;
    logic signed [13:0] ssum;

    assign a_seg = acc_base[12*gi +: 12];
    assign b_seg = word_0[12*gi +: 12];
    assign c_seg = word_1[12*gi +: 12];

    if (gi == 0) begin : gen_cin_first
      assign cin = 2'd0;
    end else begin : gen_cin_chain
      assign cin = seg_link[gi] ? gen_seg[gi-1].usum[13:12] : 2'd0;
    end

    assign usum = {2'b00, a_seg} + {2'b00, b_seg} + {2'b00, c_seg} + {12'd0, cin};
    assign ssum = $signed({{2{a_seg[11]}}, a_seg}) + $signed({{2{b_seg[11]}}, b_seg})
                + $signed({{2{c_seg[11]}}, c_seg}) + $signed({12'd0, cin});

    assign sum_word[12*gi +: 12] = usum[11:0];
    assign seg_ovf[gi] = sign_eff ? ((ssum > 14'sd2047) || (ssum < -14'sd2048))
                                  : (usum[13:12] != 2'd0);
  end

  // Only segments that end a lane report overflow; map them to lane index.
  always_comb begin
    ovf_add = 4'b0000;
    case (mode_eff)
      2'b00:   ovf_add = {3'b000, seg_ovf[3]};
      2'b01:   ovf_add = {2'b00, seg_ovf[3], seg_ovf[1]};
      default: ovf_add = seg_ovf;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_next = (len_eff == 8'd1) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept && (cnt_inc == len_reg)) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Accumulator datapath. Nothing here changes in HOLD because accept is
  // forced low there, which keeps the result stable for the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg      <= '0;
      ovf_reg      <= 4'b0000;
      carry_or_reg <= 16'h0000;
      cnt_reg      <= 8'd0;
      len_reg      <= 8'd1;
      mode_reg     <= 2'b00;
      sign_reg     <= 1'b0;
    end else if (accept) begin
      acc_reg <= sum_word;
      if (first_beat) begin
        mode_reg     <= mode;
        sign_reg     <= in_sign;
        len_reg      <= len_eff;
        cnt_reg      <= 8'd1;
        ovf_reg      <= ovf_add;
        carry_or_reg <= in_simd_carry;
      end else begin
        cnt_reg      <= cnt_inc;
        ovf_reg      <= ovf_reg | ovf_add;
        carry_or_reg <= carry_or_reg | in_simd_carry;
      end
    end
  end

  assign out_acc      = acc_reg;
  assign out_ovf      = ovf_reg;
  assign out_carry_or = carry_or_reg;

endmodule

// File: doc/mult_result_accumulator.md
MULT_RESULT_ACCUMULATOR -- requirements
Module: mult_result_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 48, accumulator width (fixed at 48 for this release).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  product words valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-006 SHALL have port in_result_0  input  45  first partial-sum word from the multiplier.
REQ-007 SHALL have port in_result_1  input  45  second partial-sum word from the multiplier.
REQ-008 SHALL have port in_simd_carry  input  16  multiplier SIMD carry bits.
REQ-009 SHALL have port in_sign  input  1  operands signed (a_sign|b_sign).
REQ-010 SHALL have port mode  input  2  00 full, 01 sum_9x9, 10 sum_4x4, 11 sum_2x2.
REQ-011 SHALL have port acc_len  input  8  products per block; 0 is treated as 1.
REQ-012 SHALL have port out_valid  output  1  accumulated block result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_acc  output  48  accumulated result.
REQ-015 SHALL have port out_ovf  output  4  sticky per-lane overflow flags.
REQ-016 SHALL have port out_carry_or  output  16  OR of in_simd_carry over the block.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-018 IDLE and ACCUM SHALL drive in_ready=1; HOLD SHALL drive in_ready=0. out_valid SHALL be 1 only in HOLD.
REQ-019 Accept SHALL occur when in_valid&in_ready.
REQ-020 First accept (in IDLE) SHALL:
  - latch mode, in_sign and max(acc_len,1);
  - load acc = 0 + P, set cnt=1, ovf = lane overflow of that add, carry_or = in_simd_carry.
REQ-021 Later accepts (in ACCUM) SHALL:
  - set acc = acc + P, cnt = cnt+1;
  - OR new lane overflows into ovf and OR in_simd_carry into carry_or.
REQ-022 Port mode, in_sign and acc_len changes after the first accept SHALL be ignored until the next block.
REQ-023 Transitions:
  - IDLE->ACCUM on accept when latched length >1;
  - IDLE->HOLD on accept when latched length =1;
  - ACCUM->HOLD on the accept that makes cnt equal the latched length;
  - HOLD->IDLE on out_valid&out_ready.
REQ-024 Latency SHALL be: out_valid asserts the cycle after the final accept. One bubble cycle (in_ready=0) SHALL occur between blocks.
REQ-025 Lane partition by latched mode:
  - 00: one lane, bits 47:0;
  - 01: two lanes, bits 23:0 and 47:24;
  - 10/11: four lanes, lane k = bits 12k+11:12k.
REQ-026 P SHALL be formed lane-wise as lane(in_result_0) + lane(in_result_1), each zero-extended to 48 bits.
  - Exception: in mode 00 with in_sign=1, each word SHALL be sign-extended from bit 44.
REQ-027 Each lane SHALL add acc_lane + r0_lane + r1_lane with no carry crossing lane boundaries, and SHALL wrap modulo 2^lane_width (no saturation).
REQ-028 A lane overflow SHALL flag when the exact three-operand sum does not fit the lane width:
  - unsigned range when in_sign=0;
  - two's-complement range when in_sign=1.
REQ-029 out_ovf bit k SHALL map to lane k. Bits for nonexistent lanes SHALL be 0.
REQ-030 out_acc, out_ovf and out_carry_or SHALL be registered and held stable throughout HOLD regardless of out_ready or input activity.
REQ-031 in_valid in HOLD SHALL be ignored and SHALL NOT be accepted.

Reset
REQ-032 reset SHALL force state=IDLE, out_valid=0, in_ready=1 (the cycle after reset is sampled), out_acc=0, out_ovf=0, out_carry_or=0, cnt=0.
REQ-033 reset SHALL take priority over any simultaneous accept or output handshake.
REQ-034 reset mid-block SHALL discard the partial accumulation; the next accept SHALL start a fresh block.

Verification
REQ-035 Mode 00, in_sign=0, acc_len=3, three accepts of r0=10, r1=5 -> out_valid one cycle after the third accept, out_acc=45, out_ovf=0.
REQ-036 Mode 00, in_sign=1, acc_len=2, two accepts of r0=45'h1FFF_FFFF_FFFF (-1), r1=0 -> out_acc=48'hFFFF_FFFF_FFFE, out_ovf=0.
REQ-037 Mode 10, in_sign=0, acc_len=1, r0=45'h0FFF, r1=1 -> out_acc=0 (lane0 wraps, lane1 receives no carry), out_ovf=4'b0001.
REQ-038 Result in HOLD with out_ready=0 for 5 cycles, in_valid=1 throughout -> in_ready=0, out_acc/out_ovf unchanged, no accept; out_ready=1 -> IDLE next cycle.
REQ-039 acc_len=4, reset asserted after 2 accepts, mode toggled 00->01 mid-block in the next run -> outputs zero and in_ready=1 the cycle after reset; the new block uses the mode latched at its first accept.
REQ-040 acc_len=0 with one accept -> treated as length 1, out_valid the next cycle; in_simd_carry=16'h8001 -> out_carry_or=16'h8001.
